bmem_line_arbiter: RTL and testbench
====================================

Name: bmem_line_arbiter

Overview:
- Sits between the I-cache / D-cache miss ports inside mp4 and the top-level burst memory port.
- Arbitrates between the two caches.
- Serializes each 256-bit cache-line transfer into a 4-beat x 64-bit burst on the bmem interface.
- Reassembles read bursts back into a full line for the requesting cache.

Parameters:
- ADDR_W, 32, address width.
- BEAT_W, 64, bmem data width per beat.
- BEATS, 4, beats per line; line width is BEAT_W*BEATS = 256.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- i_addr  in  ADDR_W  I-cache line address.
- i_read  in  1  I-cache read request, level, held until i_resp.
- i_rdata  out  BEAT_W*BEATS  returned line.
- i_resp  out  1  one-cycle completion pulse.
- d_addr  in  ADDR_W  D-cache line address.
- d_read  in  1  D-cache read request, level.
- d_write  in  1  D-cache writeback request, level.
- d_wdata  in  BEAT_W*BEATS  writeback line.
- d_rdata  out  BEAT_W*BEATS  returned line.
- d_resp  out  1  one-cycle completion pulse.
- bmem_address  out  ADDR_W  burst address.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  write beat.
- bmem_rdata  in  BEAT_W  read beat.
- bmem_resp  in  1  read beat valid / write complete.

Behaviour:
- Reset (rst==0 at posedge):
  - State IDLE, beat counter 0, last_grant=D.
  - All outputs 0: i_rdata, d_rdata, bmem_address, bmem_wdata and all strobes/resps.
  - Reset mid-burst aborts immediately; bmem_resp beats arriving afterwards are ignored in IDLE.
- States: IDLE, RD_REQ, RD_BEAT, WR_BEAT, WR_WAIT, DONE.
- IDLE:
  - Requester pending: I = i_read; D = d_read|d_write.
  - If only one is pending, grant it.
  - If both are pending, grant the one not equal to last_grant (alternation).
  - Latch owner, op (write if d_write, else read), and aligned address {addr[31:5],5'b0}.
  - Go to RD_REQ for a read, WR_BEAT for a write. last_grant updates on grant.
  - d_read and d_write both high: treated as a write.
- RD_REQ:
  - bmem_read=1 for exactly one cycle with the aligned bmem_address.
  - bmem_address stays stable until DONE.
  - Next state RD_BEAT.
- RD_BEAT:
  - Each cycle with bmem_resp=1, store bmem_rdata into line slice [cnt*64 +: 64] and increment cnt (beat 0 = lowest bits).
  - Cycles with bmem_resp=0 are waited through.
  - After beat BEATS-1: cnt wraps to 0, next state DONE.
- WR_BEAT:
  - bmem_write=1 for BEATS consecutive cycles, bmem_wdata = d_wdata[cnt*64 +: 64].
  - cnt increments every cycle; after beat 3, go to WR_WAIT.
  - d_wdata is sampled into a holding register at grant.
- WR_WAIT: bmem_write=0; wait for bmem_resp=1, then DONE.
- DONE:
  - Pulse the owner's resp for one cycle.
  - On a read, the owner's rdata register holds the full line; it remains stable until that owner's next read completes.
  - Next state IDLE.
  - Requests seen during DONE are not granted; the cache drops its request after resp.
- Latency: I read with immediate memory beats is 1 (grant) + 1 (RD_REQ) + 4 beats + 1 (DONE) = 7 cycles from request to resp.
- A non-owner request stays pending without loss; it is granted in the first IDLE after DONE.
- Never assert bmem_read and bmem_write in the same cycle.
- Never pulse i_resp and d_resp in the same cycle.

Test Plan:
- Reset, then i_read with i_addr=0x6000_0034 and memory beats 0x11..,0x22..,0x33..,0x44.. -> bmem_address=0x6000_0020; one bmem_read pulse; i_resp at cycle 7; i_rdata={0x44..,0x33..,0x22..,0x11..}.
- d_write with d_addr=0x8000_0040 and d_wdata beats A,B,C,D -> bmem_write high 4 cycles carrying A,B,C,D in order; d_resp one cycle after bmem_resp.
- i_read and d_read asserted in the same cycle after reset (last_grant=D) -> I is served first, then D. Repeat with both pending -> order alternates.
- Read burst with 2-cycle gaps between bmem_resp beats -> line assembled correctly; resp delayed by exactly the gap cycles.
- rst=0 during beat 2 of a write, then released with stray bmem_resp pulses -> outputs 0, state IDLE; stray pulses produce no i_resp/d_resp.
- d_read and d_write both high -> write burst issued; bmem_read never asserted.

Source files
------------

// File: rtl/bmem_line_arbiter.sv
// Arbitrates I/D cache line misses onto a 4-beat burst memory port; read latency 7 cycles with back-to-back beats.
// No backpressure on the caches: requests are levels held until the one-cycle resp; bmem beats are waited for.
module bmem_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic                    i_read,
  output logic [BEAT_W*BEATS-1:0] i_rdata,
  output logic                    i_resp,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [BEAT_W*BEATS-1:0] d_wdata,
  output logic [BEAT_W*BEATS-1:0] d_rdata,
  output logic                    d_resp,
  output logic [ADDR_W-1:0]       bmem_address,
  output logic                    bmem_read,
  output logic                    bmem_write,
  output logic [BEAT_W-1:0]       bmem_wdata,
  input  logic [BEAT_W-1:0]       bmem_rdata,
  input  logic                    bmem_resp
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_BEAT, WR_BEAT, WR_WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;  // 1 = D-cache
  logic                owner_q, owner_d;            // 1 = D-cache
  logic [LINE_W-1:0]   line_q, line_d;              // read assembly or write holding buffer
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;
  logic [ADDR_W-1:0]   bmem_address_q, bmem_address_d;
  logic                bmem_read_q, bmem_read_d;
  logic                bmem_write_q, bmem_write_d;
  logic [BEAT_W-1:0]   bmem_wdata_q, bmem_wdata_d;

  logic                i_pend, d_pend, grant_d_side;
  logic [ADDR_W-1:0]   grant_addr;
  logic                unused_addr_bits;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // On a tie the side that did not win last time goes first.
  assign grant_d_side = d_pend && !(i_pend && last_grant_q);
  assign grant_addr = grant_d_side ? {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                   : {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    line_d         = line_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    bmem_address_d = bmem_address_q;
    i_resp_d       = 1'b0;
    d_resp_d       = 1'b0;
    bmem_read_d    = 1'b0;
    bmem_write_d   = 1'b0;
    bmem_wdata_d   = '0;
    case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          owner_d        = grant_d_side;
          last_grant_d   = grant_d_side;
          bmem_address_d = grant_addr;
          cnt_d          = '0;
          if (grant_d_side && d_write) begin
            state_d      = WR_BEAT;
            line_d       = d_wdata;
            bmem_write_d = 1'b1;
            bmem_wdata_d = d_wdata[BEAT_W-1:0];
          end else begin
            state_d     = RD_REQ;
            bmem_read_d = 1'b1;
          end
        end
      end
      RD_REQ: state_d = RD_BEAT;
      RD_BEAT: begin
        if (bmem_resp) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
            if (owner_q) begin
              d_rdata_d = line_d;
              d_resp_d  = 1'b1;
            end else begin
              i_rdata_d = line_d;
              i_resp_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      WR_BEAT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = WR_WAIT;
        end else begin
          cnt_d        = cnt_q + CNT_ONE;
          bmem_write_d = 1'b1;
          bmem_wdata_d = line_q[cnt_d*BEAT_W +: BEAT_W];
        end
      end
      WR_WAIT: begin
        if (bmem_resp) begin
          state_d  = DONE;
          d_resp_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      line_q         <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      bmem_address_q <= '0;
      bmem_read_q    <= 1'b0;
      bmem_write_q   <= 1'b0;
      bmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      line_q         <= line_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      i_resp_q       <= i_resp_d;
      d_resp_q       <= d_resp_d;
      bmem_address_q <= bmem_address_d;
      bmem_read_q    <= bmem_read_d;
      bmem_write_q   <= bmem_write_d;
      bmem_wdata_q   <= bmem_wdata_d;
    end
  end

  assign i_rdata      = i_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_rdata      = d_rdata_q;
  assign d_resp       = d_resp_q;
  assign bmem_address = bmem_address_q;
  assign bmem_read    = bmem_read_q;
  assign bmem_write   = bmem_write_q;
  assign bmem_wdata   = bmem_wdata_q;

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Bench for bmem_line_arbiter: vector table, reset-abort sequence, then random cache traffic against a burst memory model.
module tb_bmem_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, bmem_address;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         bmem_read, bmem_write, bmem_resp;
  logic [63:0]  bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  bmem_line_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  typedef struct packed {
    logic        ir, dr, dw;
    logic [31:0] ia, da;
    logic [3:0]  gap;
    logic        first_d;
    logic [7:0]  lat1, lat2;
  } vec_t;

  vec_t vecs [8];

  int vec_cnt = 0, mis_cnt = 0;
  int viol = 0, run_err = 0, rd_pulses = 0, exp_rd_bursts = 0;
  int mem_gap = 0, stray_left = 0;
  bit mem_rand = 1'b0;
  logic [255:0] exp_i_line = '0, exp_d_line = '0;

  bit           rd_active = 1'b0, wr_pend = 1'b0;
  int           rbeat = 0, gcnt = 0, wcnt = 0, wrun = 0, rrun = 0, wdly = 0;
  logic [31:0]  rd_addr = '0, wr_addr = '0;
  logic [255:0] wr_line = '0;

  function automatic logic [63:0] beat_data(logic [31:0] a, int b);
    logic [63:0] pat;
    pat = 64'h1111_1111_1111_1111 * 64'(b + 1);
    if (a == 32'h6000_0020) return pat;
    return pat ^ {a, ~a};
  endfunction

  function automatic logic [255:0] line_of(logic [31:0] a);
    logic [255:0] l;
    for (int b = 0; b < 4; b++) l[b*64 +: 64] = beat_data(a, b);
    return l;
  endfunction

  function automatic logic [31:0] align(logic [31:0] a);
    return a - (a % 32);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_lines(input string tag);
    chk({tag, "_i_rdata"}, i_rdata, exp_i_line);
    chk({tag, "_d_rdata"}, d_rdata, exp_d_line);
  endtask

  // Burst memory model plus protocol monitors, acting just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    bmem_resp  = 1'b0;
    bmem_rdata = {$urandom, $urandom};
    if (!rst) begin
      rd_active = 1'b0; wr_pend = 1'b0; wcnt = 0; wrun = 0; rrun = 0;
    end else begin
      if (bmem_read && bmem_write) viol++;
      if (i_resp && d_resp) viol++;
      if (bmem_write) wrun++;
      else begin
        if (wrun != 0 && wrun != 4) run_err++;
        wrun = 0;
      end
      if (bmem_read) rrun++;
      else begin
        if (rrun > 1) run_err++;
        rrun = 0;
      end
      if (stray_left > 0) begin
        bmem_resp = 1'b1;
        stray_left--;
      end else if (wr_pend) begin
        if (wdly == 0) begin bmem_resp = 1'b1; wr_pend = 1'b0; end
        else wdly--;
      end else if (rd_active) begin
        if (gcnt == 0) begin
          bmem_resp  = 1'b1;
          bmem_rdata = beat_data(rd_addr, rbeat);
          rbeat++;
          gcnt = mem_rand ? int'($urandom_range(0, 2)) : mem_gap;
          if (rbeat == 4) rd_active = 1'b0;
        end else gcnt--;
      end
      if (bmem_read) begin
        rd_active = 1'b1; rbeat = 0; gcnt = 0; rd_addr = bmem_address; rd_pulses++;
      end
      if (bmem_write) begin
        if (wcnt == 0) wr_addr = bmem_address;
        wr_line[wcnt*64 +: 64] = bmem_wdata;
        wcnt++;
        if (wcnt == 4) begin
          wcnt = 0; wr_pend = 1'b1;
          wdly = mem_rand ? int'($urandom_range(0, 3)) : 0;
        end
      end
    end
  end

  task automatic apply_vec(input int k, input vec_t v);
    logic [255:0] wd;
    int n, served, rp0;
    bit ip, dp, exp_d;
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mem_gap = int'(v.gap);
    i_addr = v.ia; d_addr = v.da; d_wdata = wd;
    i_read = v.ir; d_read = v.dr; d_write = v.dw;
    ip = v.ir; dp = v.dr | v.dw;
    n = 1; served = 0; rp0 = rd_pulses;
    while ((ip || dp) && n < 100) begin
      @(negedge clk);
      n++;
      if (i_resp || d_resp) begin
        exp_d = (served == 0) ? v.first_d : !v.first_d;
        chk($sformatf("v%0d_owner%0d", k, served), d_resp, exp_d);
        chk($sformatf("v%0d_lat%0d", k, served), n, (served == 0) ? v.lat1 : v.lat2);
        if (i_resp) begin
          exp_i_line = line_of(align(v.ia));
          exp_rd_bursts++;
          i_read = 1'b0; ip = 1'b0;
        end
        if (d_resp) begin
          if (v.dw) begin
            chk($sformatf("v%0d_wline", k), wr_line, wd);
            chk($sformatf("v%0d_waddr", k), wr_addr, align(v.da));
          end else begin
            exp_d_line = line_of(align(v.da));
            exp_rd_bursts++;
          end
          d_read = 1'b0; d_write = 1'b0; dp = 1'b0;
        end
        check_lines($sformatf("v%0d_r%0d", k, served));
        served++;
      end
    end
    chk($sformatf("v%0d_all_served", k), {ip, dp}, 2'b00);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_rd_pulses", k), rd_pulses - rp0, int'(v.ir) + int'(v.dr & ~v.dw));
  endtask

  bit           i_on = 1'b0, d_on = 1'b0, d_wr = 1'b0;
  int           i_skips = 0, d_skips = 0, i_wait = 0, d_wait = 0;
  logic [31:0]  ia_r = '0, da_r = '0;
  logic [255:0] wd_r = '0;

  initial begin
    logic [255:0] wd;
    int n;
    vec_t pv;
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    //           ir    dr    dw    i_addr         d_addr         gap   1st_d lat1   lat2
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h6000_0034, 32'h0000_0000, 4'd0, 1'b0, 8'd7,  8'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8000_0040, 4'd0, 1'b1, 8'd7,  8'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h2000_0044, 4'd0, 1'b0, 8'd7,  8'd14};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h3000_0088, 32'h0000_0000, 4'd0, 1'b0, 8'd7,  8'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h5000_00A0, 32'h5000_1000, 4'd0, 1'b1, 8'd7,  8'd14};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h4000_0013, 4'd2, 1'b1, 8'd13, 8'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h9000_0060, 4'd0, 1'b1, 8'd7,  8'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'hA000_0100, 32'hB000_0020, 4'd0, 1'b0, 8'd7,  8'd14};

    repeat (3) @(negedge clk);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_bmem_address", bmem_address, '0);
    chk("rst_bmem_wdata", bmem_wdata, '0);
    chk("rst_strobes", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      apply_vec(k, vecs[k]);
      if (k == 0)
        chk("plan_i_rdata", i_rdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    end

    // Reset lands while the third write beat is on the bus.
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d_addr = 32'h8000_0040; d_wdata = wd; d_write = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_beat2_valid", bmem_write, 1'b1);
    chk("abort_beat2_data", bmem_wdata, wd[191:128]);
    rst = 1'b0; d_write = 1'b0;
    @(negedge clk);
    exp_i_line = '0; exp_d_line = '0;
    check_lines("abort");
    chk("abort_bmem_address", bmem_address, '0);
    chk("abort_bmem_wdata", bmem_wdata, '0);
    chk("abort_strobes", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
    @(negedge clk);
    rst = 1'b1; stray_left = 3;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (i_resp || d_resp || bmem_read || bmem_write) n++;
    end
    chk("stray_activity", n, 0);
    pv = '{1'b1, 1'b0, 1'b0, 32'h7000_001F, 32'h0, 4'd0, 1'b0, 8'd7, 8'd0};
    apply_vec(8, pv);

    // Random traffic from both caches with jittered memory timing.
    mem_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_on) i_wait++;
      if (d_on) d_wait++;
      if (i_resp) begin
        chk("rnd_i_requested", i_on, 1'b1);
        exp_i_line = line_of(align(ia_r));
        exp_rd_bursts++;
        if (d_on) begin
          d_skips++;
          chk("rnd_fair_d", d_skips <= 1, 1'b1);
        end
        i_read = 1'b0; i_on = 1'b0;
        chk("rnd_i_wait", i_wait <= 100, 1'b1);
      end
      if (d_resp) begin
        chk("rnd_d_requested", d_on, 1'b1);
        if (d_wr) begin
          chk("rnd_wline", wr_line, wd_r);
          chk("rnd_waddr", wr_addr, align(da_r));
        end else begin
          exp_d_line = line_of(align(da_r));
          exp_rd_bursts++;
        end
        if (i_on) begin
          i_skips++;
          chk("rnd_fair_i", i_skips <= 1, 1'b1);
        end
        d_read = 1'b0; d_write = 1'b0; d_on = 1'b0;
        chk("rnd_d_wait", d_wait <= 100, 1'b1);
      end
      if (i_resp || d_resp) check_lines("rnd");
      if (c < 2800 && !i_on && !i_resp && $urandom_range(0, 3) == 0) begin
        ia_r = $urandom; i_addr = ia_r; i_read = 1'b1;
        i_on = 1'b1; i_skips = 0; i_wait = 0;
      end
      if (c < 2800 && !d_on && !d_resp && $urandom_range(0, 3) == 0) begin
        da_r = $urandom; d_addr = da_r;
        wd_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d_wdata = wd_r;
        d_wr = ($urandom_range(0, 2) == 0);
        d_write = d_wr;
        d_read = d_wr ? 1'($urandom_range(0, 1)) : 1'b1;
        d_on = 1'b1; d_skips = 0; d_wait = 0;
      end
    end

    chk("end_i_drained", i_on, 1'b0);
    chk("end_d_drained", d_on, 1'b0);
    chk("end_protocol_viol", viol, 0);
    chk("end_burst_len_err", run_err, 0);
    chk("end_rd_pulses", rd_pulses, exp_rd_bursts);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
